// File: rtl/seg_pkg.sv
// seg_pkg: shared seven-segment constants for the scanned display driver and its decoder.
//   Patterns are active-low, written g..a (bit6 = g, bit0 = a).
//   UNITS/TENS/HUNDREDS are the digit-enable indices within a frame.
package seg_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam int UNITS    = 0;
    localparam int TENS     = 1;
    localparam int HUNDREDS = 2;

    // Encoder used by the display driver; values above 9 map to blank.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = SEG_0;
            4'd1:    p = SEG_1;
            4'd2:    p = SEG_2;
            4'd3:    p = SEG_3;
            4'd4:    p = SEG_4;
            4'd5:    p = SEG_5;
            4'd6:    p = SEG_6;
            4'd7:    p = SEG_7;
            4'd8:    p = SEG_8;
            4'd9:    p = SEG_9;
            default: p = SEG_BLANK;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/seg7_to_bcd.sv
// seg7_to_bcd: combinational decode of an active-low seven-segment pattern to BCD.
//   pattern  in   7  active-low segments, bit0 = a .. bit6 = g
//   digit    out  4  decoded BCD digit (0 for blank or illegal patterns)
//   ok       out  1  pattern is a legal digit or blank
//   blank    out  1  pattern is all segments off
module seg7_to_bcd
    import seg_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] digit,
    output logic       ok,
    output logic       blank
);

    always_comb begin
        digit = 4'd0;
        ok    = 1'b1;
        blank = 1'b0;
        case (pattern)
            SEG_0:     digit = 4'd0;
            SEG_1:     digit = 4'd1;
            SEG_2:     digit = 4'd2;
            SEG_3:     digit = 4'd3;
            SEG_4:     digit = 4'd4;
            SEG_5:     digit = 4'd5;
            SEG_6:     digit = 4'd6;
            SEG_7:     digit = 4'd7;
            SEG_8:     digit = 4'd8;
            SEG_9:     digit = 4'd9;
            SEG_BLANK: blank = 1'b1;
            default:   ok    = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: debounces a scanned active-low 7-seg bus and reassembles BCD frames.
//   clk          in   1       system clock
//   rst          in   1       asynchronous active-high reset
//   seg          in   7       active-low segment pattern, bit0 = a .. bit6 = g
//   en           in   NDIG    active-low digit enables, en[0] = units
//   digits       out  4*NDIG  committed BCD frame, digit i at [4i+3:4i]
//   value        out  VW      binary value of digits
//   frame_valid  out  1       a committed frame is present
//   frame_pulse  out  1       one-cycle strobe on each frame commit
//   seg_err      out  1       one-cycle strobe on an illegal stable segment pattern
//   en_err       out  1       one-cycle strobe on an illegal stable enable pattern
module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter int NDIG   = 3,
    parameter int STABLE = 4,
    parameter int VW     = $clog2(10**NDIG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [6:0]        seg,
    input  logic [NDIG-1:0]   en,
    output logic [4*NDIG-1:0] digits,
    output logic [VW-1:0]     value,
    output logic              frame_valid,
    output logic              frame_pulse,
    output logic              seg_err,
    output logic              en_err
);

    localparam int         SW     = NDIG + 7;
    localparam logic [3:0] MC_CAP = 4'(STABLE - 2);
    localparam logic [3:0] MC_MAX = 4'(STABLE);

    logic [SW-1:0]     s;
    logic [SW-1:0]     smp;
    logic [3:0]        mc;
    logic [4*NDIG-1:0] shadow;
    logic [4*NDIG-1:0] shadow_n;
    logic [NDIG-1:0]   seen;
    logic [NDIG-1:0]   seen_n;
    logic [NDIG-1:0]   lows;
    logic [3:0]        dig_raw;
    logic [3:0]        dig;
    logic              ok;
    logic              blank;
    logic              cap;
    logic              one_low;
    logic              multi_low;
    logic              wr;
    logic              commit;
    logic              e_en;
    logic              e_seg;
    logic [VW-1:0]     value_n;

    assign smp  = {en, seg};
    assign lows = ~s[SW-1:7];

    // x & (x-1) is non-zero exactly when more than one bit of x is set.
    assign multi_low = (lows & (lows - NDIG'(1))) != '0;
    assign one_low   = lows != '0 && !multi_low;

    seg7_to_bcd u_dec (
        .pattern (s[6:0]),
        .digit   (dig_raw),
        .ok      (ok),
        .blank   (blank)
    );

    // Blanked digits are leading zeros.
    assign dig = blank ? 4'd0 : dig_raw;

    // Fires on the single edge where mc steps STABLE-2 -> STABLE-1.
    assign cap   = smp == s && mc == MC_CAP;
    assign e_en  = cap && multi_low;
    assign e_seg = cap && one_low && !ok;
    assign wr    = cap && one_low && ok;

    always_comb begin
        shadow_n = shadow;
        for (int i = 0; i < NDIG; i++)
            if (wr && lows[i]) shadow_n[4*i +: 4] = dig;
        seen_n  = wr ? seen | lows : seen;
        commit  = wr && &seen_n;
        value_n = '0;
        for (int i = NDIG - 1; i >= 0; i--)
            value_n = value_n * VW'(10) + VW'(shadow_n[4*i +: 4]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s           <= '0;
            mc          <= '0;
            shadow      <= '0;
            seen        <= '0;
            digits      <= '0;
            value       <= '0;
            frame_valid <= 1'b0;
            frame_pulse <= 1'b0;
            seg_err     <= 1'b0;
            en_err      <= 1'b0;
        end else begin
            s           <= smp;
            mc          <= smp != s ? 4'd0 : mc < MC_MAX ? mc + 4'd1 : mc;
            shadow      <= shadow_n;
            seen        <= commit || e_en || e_seg ? '0 : seen_n;
            frame_pulse <= commit;
            seg_err     <= e_seg;
            en_err      <= e_en;
            frame_valid <= commit ? 1'b1 : e_seg ? 1'b0 : frame_valid;
            if (commit) begin
                digits <= shadow_n;
                value  <= value_n;
            end
        end
    end

endmodule

// File: doc/seg_scan_decoder.md
# seg_scan_decoder

Receive-side companion to the team's multiplexed 3-digit seven-segment display driver. The block samples the active-low segment bus and the active-low digit enables, debounces each scan slot, and decodes each pattern back to BCD. It reassembles complete frames and presents both the BCD digits and their binary value. It sits in the self-check/loopback path of display designs, or behind a scanned-display input.

## Interface
- NDIG, 3: digits per frame. en[0] is units, en[1] is tens, en[2] is hundreds.
- STABLE, 4: consecutive identical samples required before a capture. Legal range is 2..15.
- VW, $clog2(10**NDIG) (10 for NDIG=3): width of `value`.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- seg  in  7  segment pattern, active-low. bit0=a … bit6=g.
- en  in  NDIG  digit enables, active-low; exactly one bit low is legal.
- digits  out  4*NDIG  committed BCD frame. Digit i occupies [4i+3:4i]. Reset value 0.
- value  out  VW  binary equivalent of `digits`. Reset value 0.
- frame_valid  out  1  a committed frame is present. Reset value 0.
- frame_pulse  out  1  one-cycle strobe on each frame commit. Reset value 0.
- seg_err  out  1  one-cycle strobe on an illegal stable segment pattern. Reset value 0.
- en_err  out  1  one-cycle strobe on an illegal stable enable pattern. Reset value 0.

## Operation
- **Sampling.** A sample register `s` loads {en, seg} every cycle.
- **Stability tracking.** A match counter `mc` (4 bits) tracks how long `s` has been unchanged.
  - If the new sample differs from `s`, `mc` goes to 0.
  - Otherwise `mc` increments, saturating at STABLE.
- **Capture.** A capture event occurs on the single edge where `mc` goes STABLE-2 → STABLE-1, i.e. at STABLE equal samples. A held pattern captures exactly once.
- **Segment decode.**
  - Digits 0–9 decode from these patterns: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000.
  - Blank (1111111) decodes as digit 0. This supports leading-zero blanking.
  - Any other pattern is an error.
- **Capture actions.**
  - **Valid enable, valid pattern:** write shadow[i] and set seen[i]. A repeat capture of the same slot overwrites shadow[i].
  - **All enables high (no enable low):** no action and no error. This is the inter-digit gap.
  - **More than one enable low:** pulse en_err and clear seen. Shadow is untouched.
  - **Valid enable, invalid pattern:** pulse seg_err, clear seen, and drop frame_valid to 0.
  - **Simultaneous enable and segment errors:** en_err takes priority. Only en_err pulses; seen is cleared and frame_valid is unchanged.
- **Commit.** When a capture would make seen all ones, the same edge performs:
  - digits ← next shadow;
  - value ← Σ digit_i·10^i;
  - frame_valid ← 1 and frame_pulse ← 1;
  - seen ← 0.
- **Arithmetic.** `value` is computed Horner-style at width VW. With BCD digits it cannot overflow: the maximum is 999 for NDIG=3.
- **Reset.** Reset at any time clears s, mc, shadow, seen and all outputs immediately. An in-progress frame is discarded.

## Timing
- **Capture latency.** Inputs set up before edge E0 are loaded into `s` at E0. They must still be present at edges E0+1 … E0+STABLE-1. The capture edge is E0+STABLE-1.
- **Output latency.** When that capture completes a frame, outputs update at E0+STABLE-1. frame_pulse is high for the cycle that follows.
- **Strobes.** frame_pulse, seg_err and en_err are each exactly one cycle wide and never asserted in back-to-back cycles from the same held pattern.
- **Glitch rejection.** A slot held for fewer than STABLE samples is ignored.
- **Source timing requirement.** The driving display must hold each slot for at least STABLE clk cycles.
- **Hold between commits.** digits and value hold their values between commits. There is no handshake; consumers qualify with frame_pulse or frame_valid.

## Structure
- **Shared package `seg_pkg`.** Holds:
  - SEG_0..SEG_9 and SEG_BLANK pattern constants (the same constants the display driver uses);
  - the digit-index constants UNITS, TENS, HUNDREDS.
- **Sub-module `seg7_to_bcd`.** Purely combinational:
  - input: 7-bit pattern;
  - outputs: 4-bit digit, `ok`, `blank`;
  - instantiated once on `s`.
- **Top level.** Holds the sampler, match counter, shadow/seen registers, commit logic and error strobes.

## Test plan
- **Reset.** Assert rst mid-frame, asynchronously between edges → all outputs and seen are 0 immediately; the next full scan commits normally.
- **Nominal scan.** STABLE=4; scan u=7, t=2, h=1, each held 6 cycles with 2-cycle all-high gaps → one frame_pulse; digits=0x127, value=127, frame_valid=1.
- **Glitch.** Hold tens=5 for 3 cycles, then tens=2 for 6 cycles → tens captured as 2, no error.
- **Invalid pattern.** seg=1010101 on en=110 for 5 cycles → single-cycle seg_err, frame_valid=0, no commit until a complete new scan.
- **Invalid enable.** en=100 for 5 cycles → single en_err, seen cleared; the previous digits and value are retained.
- **Blanking and wrap.** Scan h blank, t blank, u=0, then h=9, t=9, u=9 → value 0 then 999; each commit produces exactly one frame_pulse.
